// File: rtl/vp_mem_pkg.sv
// Shared definitions for the vector/scalar memory access stage: mem_op bit
// indices, lane geometry and the access FSM state encoding.
package vp_mem_pkg;

    localparam int OP_W      = 4;
    localparam int OP_SREAD  = 0;
    localparam int OP_SWRITE = 1;
    localparam int OP_VREAD  = 2;
    localparam int OP_VWRITE = 3;

    localparam int LANES    = 8;
    localparam int LANE_W   = 24;
    localparam int SCALAR_W = 21;
    localparam int VEC_W    = LANES * LANE_W;
    localparam int BEAT_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SREAD,
        ST_SWRITE,
        ST_VREAD,
        ST_VWRITE,
        ST_DONE
    } mem_state_e;

    // A request is legal only when it names exactly one kind of access.
    function automatic logic op_single(input logic [OP_W-1:0] op);
        return $countones(op) == 1;
    endfunction

endpackage

// File: rtl/vec_lane_pack.sv
// Combinational lane extract / lane insert on a packed 8 x 24-bit vector,
// each selected by its own 3-bit lane index.
module vec_lane_pack
    import vp_mem_pkg::*;
(
    input  logic [VEC_W-1:0]  ext_vec,
    input  logic [BEAT_W-1:0] ext_idx,
    output logic [LANE_W-1:0] ext_lane,
    input  logic [VEC_W-1:0]  ins_vec,
    input  logic [BEAT_W-1:0] ins_idx,
    input  logic [LANE_W-1:0] ins_lane,
    output logic [VEC_W-1:0]  ins_out
);

    logic [LANES-1:0][LANE_W-1:0] ext_arr;
    logic [LANES-1:0][LANE_W-1:0] ins_arr;
    logic [LANES-1:0][LANE_W-1:0] out_arr;

    assign ext_arr  = ext_vec;
    assign ins_arr  = ins_vec;
    assign ext_lane = ext_arr[ext_idx];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign out_arr[i] = (ins_idx == BEAT_W'(i)) ? ins_lane : ins_arr[i];
    end

    assign ins_out = out_arr;

endmodule

// File: rtl/vec_mem_access.sv
// MEM-stage access engine: scalar/vector loads and stores to a synchronous
// 24-bit memory. Define VEC_MEM_BOUNDS_CHECK_EN to reject out-of-range requests.
module vec_mem_access
    import vp_mem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [OP_W-1:0]     mem_op,
    input  logic [SCALAR_W-1:0] addr_in,
    input  logic [SCALAR_W-1:0] sdata_in,
    input  logic [VEC_W-1:0]    vdata_in,
    output logic                stall,
    output logic                done,
    output logic                err,
    output logic [SCALAR_W-1:0] sdata_out,
    output logic [VEC_W-1:0]    vdata_out,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [LANE_W-1:0]   mem_wdata,
    input  logic [LANE_W-1:0]   mem_rdata
);

`ifdef VEC_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    mem_state_e state, state_nxt;

    logic [BEAT_W-1:0]   beat_q;
    logic                tail_q;
    logic [ADDR_W-1:0]   base_q;
    logic [SCALAR_W-1:0] sdata_q;
    logic [VEC_W-1:0]    vdata_q;

    logic                rd_issue;
    logic                rd_vld;
    logic                rd_scalar;
    logic [BEAT_W-1:0]   rd_idx;

    logic [LANE_W-1:0]   wr_lane;
    logic [VEC_W-1:0]    vdata_ins;

    // ---------------------------------------------------------------- request decode
    logic [ADDR_W-1:0] req_base;
    logic [31:0]       req_last;
    logic              req_vec, req_single, req_oob, accept, reject;

    assign req_base   = addr_in[ADDR_W-1:0];
    assign req_vec    = mem_op[OP_VREAD] | mem_op[OP_VWRITE];
    assign req_single = op_single(mem_op);
    assign req_last   = 32'(req_base) + (req_vec ? 32'd7 : 32'd0);
    assign req_oob    = BOUNDS_EN && (req_last > 32'(MEM_DEPTH - 1));

    assign accept = (state == ST_IDLE) && req_valid && req_single && !req_oob;
    assign reject = (state == ST_IDLE) && req_valid && (mem_op != '0) &&
                    (!req_single || req_oob);

    if (ADDR_W < SCALAR_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_in[SCALAR_W-1:ADDR_W];
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (mem_op[OP_SREAD])       state_nxt = ST_SREAD;
                    else if (mem_op[OP_SWRITE]) state_nxt = ST_SWRITE;
                    else if (mem_op[OP_VREAD])  state_nxt = ST_VREAD;
                    else                        state_nxt = ST_VWRITE;
                end
            end
            ST_SWRITE: state_nxt = ST_DONE;
            ST_SREAD:  if (tail_q) state_nxt = ST_DONE;
            ST_VWRITE: if (beat_q == '1) state_nxt = ST_DONE;
            ST_VREAD:  if (tail_q) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        rd_issue  = 1'b0;
        mem_addr  = base_q + ADDR_W'(beat_q);
        unique case (state)
            ST_SREAD: begin
                stall    = 1'b1;
                rd_issue = !tail_q;
            end
            ST_SWRITE: begin
                stall     = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = {{(LANE_W-SCALAR_W){1'b0}}, sdata_q};
            end
            ST_VREAD: begin
                stall    = 1'b1;
                rd_issue = !tail_q;
            end
            ST_VWRITE: begin
                stall     = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = wr_lane;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- beat sequencing
    // tail_q marks the trailing cycle of a read, spent waiting for the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            tail_q <= 1'b0;
        end else begin
            unique case (state)
                ST_SREAD:  tail_q <= 1'b1;
                ST_VWRITE: beat_q <= beat_q + BEAT_W'(1);
                ST_VREAD: begin
                    if (!tail_q) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (beat_q == '1) tail_q <= 1'b1;
                    end
                end
                default: begin
                    beat_q <= '0;
                    tail_q <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- request latch, err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            sdata_q <= '0;
            vdata_q <= '0;
            err     <= 1'b0;
        end else begin
            err <= reject;
            if (accept) begin
                base_q  <= req_base;
                sdata_q <= sdata_in;
                vdata_q <= vdata_in;
            end
        end
    end

    // ---------------------------------------------------------------- load capture
    // Memory returns data one cycle after the address, so each issued read
    // remembers its destination for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld    <= 1'b0;
            rd_scalar <= 1'b0;
            rd_idx    <= '0;
            sdata_out <= '0;
            vdata_out <= '0;
        end else begin
            rd_vld    <= rd_issue;
            rd_scalar <= (state == ST_SREAD);
            rd_idx    <= beat_q;
            if (rd_vld) begin
                if (rd_scalar) sdata_out <= mem_rdata[SCALAR_W-1:0];
                else           vdata_out <= vdata_ins;
            end
        end
    end

    vec_lane_pack u_lane_pack (
        .ext_vec  (vdata_q),
        .ext_idx  (beat_q),
        .ext_lane (wr_lane),
        .ins_vec  (vdata_out),
        .ins_idx  (rd_idx),
        .ins_lane (mem_rdata),
        .ins_out  (vdata_ins)
    );

endmodule

// File: tb/tb_vec_mem_access.sv
// Directed bench for vec_mem_access with a behavioural synchronous memory.
module tb_vec_mem_access;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [3:0]   mem_op = '0;
    logic [20:0]  addr_in = '0;
    logic [20:0]  sdata_in = '0;
    logic [191:0] vdata_in = '0;
    logic         stall, done, err, mem_we;
    logic [20:0]  sdata_out;
    logic [191:0] vdata_out;
    logic [9:0]   mem_addr;
    logic [23:0]  mem_wdata;
    logic [23:0]  mem_rdata;

    logic [23:0]  mem [0:1023];
    logic         pl_en = 1'b0;
    logic [9:0]   pl_addr = '0;
    logic [23:0]  pl_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vec_mem_access #(.ADDR_W(10), .MEM_DEPTH(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .mem_op    (mem_op),
        .addr_in   (addr_in),
        .sdata_in  (sdata_in),
        .vdata_in  (vdata_in),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .sdata_out (sdata_out),
        .vdata_out (vdata_out),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr] <= mem_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [3:0]   op;
        logic [20:0]  addr;
        logic [20:0]  sdata;
        logic [191:0] vdata;
        int           done_lat;
        int           stall_n;
        int           err_n;
        int           we_n;
        logic [20:0]  exp_sdata;
        logic [191:0] exp_vdata;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [191:0] lanes(input logic [23:0] b);
        logic [191:0] v;
        for (int k = 0; k < 8; k++) v[24*k +: 24] = b + 24'(k);
        return v;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input int a, input logic [23:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = 10'(a); pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Present one request for a single cycle, then watch a bounded window.
    task automatic run_req(input logic [3:0] op, input logic [20:0] a, input logic [20:0] sd,
                           input logic [191:0] vd, output int done_lat, output int stall_n,
                           output int err_n, output int we_n);
        @(negedge clk);
        req_valid = 1'b1; mem_op = op; addr_in = a; sdata_in = sd; vdata_in = vd;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_op = '0;
        done_lat = -1; stall_n = 0; err_n = 0; we_n = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (done && done_lat < 0) done_lat = n - 1;
            if (err) err_n++;
            if (mem_we) we_n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dl, sn, en, wn;
        int v_dl, v_we, v_err;
        logic [23:0] exp_w0;
        logic [191:0] l1, la0, lb0, lc0;

        l1  = lanes(24'h000001);
        la0 = lanes(24'h0000A0);
        lb0 = lanes(24'h0000B0);
        lc0 = lanes(24'h0000C0);
`ifdef VEC_MEM_BOUNDS_CHECK_EN
        v_dl = -1; v_we = 0; v_err = 1; exp_w0 = 24'h0;
`else
        v_dl = 8;  v_we = 8; v_err = 0; exp_w0 = 24'hA4;
`endif

        //           op       addr        sdata       vdata lat st er we  exp_sdata   exp_vdata
        tbl[0]  = '{4'b0010, 21'd5,      21'h1ABCDE, '0,   1,  1, 0, 1, 21'h0,      '0};
        tbl[1]  = '{4'b0001, 21'd5,      21'h0,      '0,   2,  2, 0, 0, 21'h1ABCDE, '0};
        tbl[2]  = '{4'b1000, 21'd16,     21'h0,      l1,   8,  8, 0, 8, 21'h1ABCDE, '0};
        tbl[3]  = '{4'b0100, 21'd16,     21'h0,      '0,   9,  9, 0, 0, 21'h1ABCDE, l1};
        tbl[4]  = '{4'b0011, 21'd5,      21'h0,      '0,  -1,  0, 1, 0, 21'h1ABCDE, l1};
        tbl[5]  = '{4'b0000, 21'd5,      21'h0,      '0,  -1,  0, 0, 0, 21'h1ABCDE, l1};
        tbl[6]  = '{4'b1100, 21'd16,     21'h0,      '0,  -1,  0, 1, 0, 21'h1ABCDE, l1};
        tbl[7]  = '{4'b0001, 21'd16,     21'h0,      '0,   2,  2, 0, 0, 21'h000001, l1};
        tbl[8]  = '{4'b0010, 21'd1023,   21'h1FFFFF, '0,   1,  1, 0, 1, 21'h000001, l1};
        tbl[9]  = '{4'b0001, 21'd1023,   21'h0,      '0,   2,  2, 0, 0, 21'h1FFFFF, l1};
        tbl[10] = '{4'b1000, 21'd1020,   21'h0,      la0, v_dl, v_we, v_err, v_we, 21'h1FFFFF, l1};
        tbl[11] = '{4'b0001, 21'd100,    21'h0,      '0,   2,  2, 0, 0, 21'h012345, l1};
        tbl[12] = '{4'b0001, 21'h1FFC05, 21'h0,      '0,   2,  2, 0, 0, 21'h1ABCDE, l1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset stall", 192'(stall), 192'(0));
        chk("reset done", 192'(done), 192'(0));
        chk("reset err", 192'(err), 192'(0));
        chk("reset mem_we", 192'(mem_we), 192'(0));
        chk("reset sdata_out", 192'(sdata_out), 192'(0));
        chk("reset vdata_out", vdata_out, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 4; a++) preload(a, 24'h0);
        preload(100, 24'hE12345);
        for (int a = 200; a < 208; a++) preload(a, 24'h0);
        preload(300, 24'h0);

        for (int i = 0; i < 13; i++) begin
            run_req(tbl[i].op, tbl[i].addr, tbl[i].sdata, tbl[i].vdata, dl, sn, en, wn);
            chk($sformatf("v%0d done_lat", i), 192'(dl), 192'(tbl[i].done_lat));
            chk($sformatf("v%0d stall_cycles", i), 192'(sn), 192'(tbl[i].stall_n));
            chk($sformatf("v%0d err_pulses", i), 192'(en), 192'(tbl[i].err_n));
            chk($sformatf("v%0d write_beats", i), 192'(wn), 192'(tbl[i].we_n));
            chk($sformatf("v%0d sdata_out", i), 192'(sdata_out), 192'(tbl[i].exp_sdata));
            chk($sformatf("v%0d vdata_out", i), vdata_out, tbl[i].exp_vdata);
        end

        chk("mem word 5", 192'(mem[5]), 192'(24'h1ABCDE));
        for (int k = 0; k < 8; k++)
            chk($sformatf("mem word %0d", 16 + k), 192'(mem[16+k]), 192'(k + 1));
        chk("mem word 0 after base 1020", 192'(mem[0]), 192'(exp_w0));
        chk("mem word 3 after base 1020", 192'(mem[3]), 192'(exp_w0 == 24'h0 ? 24'h0 : 24'hA7));

        // A request raised while busy must be ignored.
        @(negedge clk);
        req_valid = 1'b1; mem_op = 4'b1000; addr_in = 21'd40; vdata_in = lc0;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_op = '0;
        dl = -1; wn = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (mem_we) wn++;
            if (done && dl < 0) dl = n - 1;
            if (n == 3) begin
                req_valid = 1'b1; mem_op = 4'b0010; addr_in = 21'd300; sdata_in = 21'h55;
            end
            if (n == 4) begin
                req_valid = 1'b0; mem_op = '0;
            end
        end
        chk("busy ignore done_lat", 192'(dl), 192'(8));
        chk("busy ignore write_beats", 192'(wn), 192'(8));
        chk("busy ignore mem word 300", 192'(mem[300]), 192'(0));
        chk("busy ignore mem word 47", 192'(mem[47]), 192'(24'hC7));

        // Reset during beat 3 of a vector write.
        @(negedge clk);
        req_valid = 1'b1; mem_op = 4'b1000; addr_in = 21'd200; vdata_in = lb0;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_op = '0;
        repeat (4) @(negedge clk);
        chk("abort beat3 mem_addr", 192'(mem_addr), 192'(203));
        chk("abort beat3 mem_we", 192'(mem_we), 192'(1));
        rst_n = 1'b0;
        #1;
        chk("abort stall", 192'(stall), 192'(0));
        chk("abort mem_we", 192'(mem_we), 192'(0));
        chk("abort done", 192'(done), 192'(0));
        chk("abort sdata_out", 192'(sdata_out), 192'(0));
        chk("abort vdata_out", vdata_out, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("abort mem word %0d", 200 + k), 192'(mem[200+k]), 192'(24'hB0 + k));
        for (int k = 4; k < 8; k++)
            chk($sformatf("abort mem word %0d", 200 + k), 192'(mem[200+k]), 192'(0));

        run_req(4'b0001, 21'd201, 21'h0, '0, dl, sn, en, wn);
        chk("post-reset read done_lat", 192'(dl), 192'(2));
        chk("post-reset read sdata_out", 192'(sdata_out), 192'(24'hB1));
        chk("post-reset read err", 192'(en), 192'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_mem_access.md
VEC_MEM_ACCESS -- requirements
Module: vec_mem_access

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the data memory.
REQ-002 Parameter MEM_DEPTH, default 1024, number of 24-bit memory words.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port req_valid  input  1  request present from the EX/MEM register.
REQ-006 Port mem_op  input  4  bit0 scalar read, bit1 scalar write, bit2 vector read, bit3 vector write.
REQ-007 Port addr_in  input  21  base word address (ALU scalar result); low ADDR_W bits used.
REQ-008 Port sdata_in  input  21  scalar store data.
REQ-009 Port vdata_in  input  192  vector store data, lane i = bits [24i+23:24i].
REQ-010 Port stall  output  1  upstream hold while access in progress.
REQ-011 Port done  output  1  one-cycle completion pulse.
REQ-012 Port err  output  1  one-cycle error pulse.
REQ-013 Port sdata_out  output  21  scalar load result.
REQ-014 Port vdata_out  output  192  vector load result.
REQ-015 Ports mem_addr (ADDR_W) / mem_we (1) / mem_wdata (24) output, mem_rdata (24) input: synchronous memory, read data valid one cycle after address.

Function
REQ-016 States: IDLE, SREAD, SWRITE, VREAD, VWRITE, DONE; one access at a time.
REQ-017 In IDLE, req_valid=1 with exactly one mem_op bit set is accepted; base address and store data latched at the accepting edge.
REQ-018 req_valid=1 with mem_op=0: no access, no done, stay IDLE.
REQ-019 req_valid=1 with more than one mem_op bit set: no memory access, err pulses the next cycle, stay IDLE.
REQ-020 req_valid while not IDLE is ignored; upstream holds its request under stall.
REQ-021 stall=1 in SREAD, SWRITE, VREAD, VWRITE; stall=0 in IDLE and DONE.
REQ-022 Scalar write: one beat, mem_wdata={3'b0,sdata}, addr=base; DONE one cycle after acceptance.
REQ-023 Scalar read: one address beat; sdata_out=mem_rdata[20:0] (upper 3 bits dropped); DONE two cycles after acceptance.
REQ-024 Vector write: beats k=0..7 on consecutive cycles, addr=base+k, data=lane k; DONE eight cycles after acceptance.
REQ-025 Vector read: addresses base+0..7 issued on consecutive cycles, lane k captured one cycle after its address; DONE nine cycles after acceptance.
REQ-026 Beat counter 3 bits; address arithmetic modulo 2^ADDR_W unless REQ-034 applies.
REQ-027 DONE lasts one cycle, done=1, then IDLE; a new request is acceptable in the cycle after DONE.
REQ-028 sdata_out/vdata_out hold their last loaded value until the next load of the same kind completes; writes do not alter them.
REQ-029 mem_we=1 only during write beats; mem_wdata=0 otherwise.

Reset
REQ-030 rst_n low forces IDLE, beat counter 0, stall/done/err/mem_we 0, sdata_out/vdata_out 0, latched request 0.
REQ-031 Reset mid-access aborts immediately; beats already written remain, no further writes, no done.

Configuration
REQ-032 Macro VEC_MEM_BOUNDS_CHECK_EN selects address range checking.
REQ-033 Without the macro: addresses wrap modulo 2^ADDR_W, err only for REQ-019.
REQ-034 With the macro: accepted request whose last word (base, or base+7 for vectors) exceeds MEM_DEPTH-1 performs no access, err pulses the next cycle, no done, state stays IDLE.

Structure
REQ-035 Shared package vp_mem_pkg holds mem_op bit indices, LANES=8, LANE_W=24, SCALAR_W=21 and the state enum.
REQ-036 One sub-module vec_lane_pack: combinational lane extract/insert by 3-bit index for 192-bit vectors.

Verification
REQ-037 Scalar write 0x1ABCDE to addr 5, then scalar read addr 5 -> mem word 0x1ABCDE; sdata_out=0x1ABCDE, done 2 cycles after accept.
REQ-038 Vector write lanes 0x000001..0x000008 at base 16, vector read base 16 -> mem words 16..23 = 1..8; vdata_out identical; stall high 8 and 9 cycles respectively.
REQ-039 mem_op=4'b0011 with req_valid -> no mem_we, err pulses once, done never asserts.
REQ-040 Vector write at base 1020: without macro, lanes 4..7 land at words 0..3; with macro, err pulse and no write.
REQ-041 rst_n low at beat 3 of vector write -> words base..base+2 or base+3 written, none after; outputs zero; next request accepted normally.
